onchip_mem_port_arbiter: RTL and testbench

Sequencer and arbiter for port s1 of the 512×64 on-chip platform RAM. It zero-fills the RAM after reset. It then shares the port between two 32-bit requesters (m0 = instruction fetch, m1 = load/store) using round-robin arbitration. Requester word addresses are steered onto the 64-bit lanes, and each read response is returned to the requester that issued it. Port s2 is not touched by this block.

---
 rtl/platform_mem_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 46 ++++
 rtl/onchip_mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_onchip_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_mem_pkg.sv
// Shared types and constants for the on-chip platform RAM port s1 sequencer.
// Contents: default RAM address width, lane-select bit index, FSM state enum,
// requester id type and the muxed request payload struct.
package platform_mem_pkg;

    localparam int unsigned MEM_AW_DEFAULT = 9;   // 512 x 64-bit words
    localparam int unsigned LANE_BIT       = 0;   // requester addr bit picking the 32-bit lane
    localparam int unsigned HALF_W         = 32;
    localparam int unsigned WORD_W         = 64;
    localparam int unsigned HALF_BE_W      = 4;
    localparam int unsigned WORD_BE_W      = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_M0 = 1'b0;
    localparam req_id_t REQ_M1 = 1'b1;

    // Per-requester payload that does not depend on the address width.
    typedef struct packed {
        logic                 we;
        logic [HALF_W-1:0]    wdata;
        logic [HALF_BE_W-1:0] be;
    } req_payload_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   req_i[1:0]     request vector (bit N = requester N)
//   advance_i      allow the last-grant pointer to move this cycle
//   gnt_o[1:0]     one-hot grant, combinational from req_i and the pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    // 1 = requester 1 was granted most recently; reset value favours requester 0.
    logic last_q;
    logic last_d;

    // Grant selection: under contention the requester not granted last wins.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer update only on an actual grant.
    always_comb begin
        last_d = last_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/onchip_mem_port_arbiter.sv
// Port s1 sequencer for the 512x64 platform RAM: zero-fills the RAM after
// reset, then shares the port between m0 (ifetch) and m1 (load/store) with
// round-robin arbitration, steering 32-bit accesses onto 64-bit lanes and
// routing each read response back to its requester.
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   mN_req/we/addr/wdata/be         requester N access (held until granted)
//   mN_gnt                          combinational accept
//   mN_rvalid/rdata                 read response, one cycle after grant
//   mem_*                           RAM port s1 (address, control, data, clken)
//   mem_readdata                    RAM q_a, valid the cycle after the address
//   init_done                       high once the zero-fill has completed
module onchip_mem_port_arbiter
    import platform_mem_pkg::*;
#(
    parameter int unsigned MEM_AW         = MEM_AW_DEFAULT,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [MEM_AW:0]        m0_addr,
    input  logic [HALF_W-1:0]      m0_wdata,
    input  logic [HALF_BE_W-1:0]   m0_be,
    output logic                   m0_gnt,
    output logic                   m0_rvalid,
    output logic [HALF_W-1:0]      m0_rdata,

    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [MEM_AW:0]        m1_addr,
    input  logic [HALF_W-1:0]      m1_wdata,
    input  logic [HALF_BE_W-1:0]   m1_be,
    output logic                   m1_gnt,
    output logic                   m1_rvalid,
    output logic [HALF_W-1:0]      m1_rdata,

    output logic [MEM_AW-1:0]      mem_address,
    output logic                   mem_chipselect,
    output logic                   mem_write,
    output logic [WORD_BE_W-1:0]   mem_byteenable,
    output logic [WORD_W-1:0]      mem_writedata,
    output logic                   mem_clken,
    input  logic [WORD_W-1:0]      mem_readdata,

    output logic                   init_done
);

    state_t              state_q;
    logic [MEM_AW-1:0]   clr_cnt_q;
    logic                init_done_q;
    logic                rvalid_q;
    req_id_t             rid_q;
    logic                rlane_q;

    logic                run_c;
    logic [1:0]          arb_req;
    logic [1:0]          arb_gnt;
    logic                any_gnt;
    logic [MEM_AW:0]     sel_addr;
    req_payload_t        sel_pl;
    logic                sel_lane;
    logic [HALF_W-1:0]   rd_half;

    // Arbitration is only live in RUN and outside reset.
    assign run_c   = reset_n && (state_q == RUN);
    assign arb_req = {m1_req, m0_req} & {2{run_c}};

    rr_arb2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (arb_req),
        .advance_i (run_c),
        .gnt_o     (arb_gnt)
    );

    assign m0_gnt  = arb_gnt[0];
    assign m1_gnt  = arb_gnt[1];
    assign any_gnt = |arb_gnt;

    // Mux the granted requester's access.
    always_comb begin
        sel_addr     = m0_addr;
        sel_pl.we    = m0_we;
        sel_pl.wdata = m0_wdata;
        sel_pl.be    = m0_be;
        if (arb_gnt[1]) begin
            sel_addr     = m1_addr;
            sel_pl.we    = m1_we;
            sel_pl.wdata = m1_wdata;
            sel_pl.be    = m1_be;
        end
    end

    assign sel_lane = sel_addr[LANE_BIT];

    // RAM port drive: zero-fill in CLEAR, granted access in RUN, idle otherwise.
    always_comb begin
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (reset_n && (state_q == CLEAR)) begin
            mem_address    = clr_cnt_q;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_byteenable = '1;
        end else if (any_gnt) begin
            mem_address    = sel_addr[MEM_AW:1];
            mem_chipselect = 1'b1;
            mem_write      = sel_pl.we;
            mem_byteenable = sel_lane ? {sel_pl.be, 4'h0} : {4'h0, sel_pl.be};
            mem_writedata  = {2{sel_pl.wdata}};
        end
    end

    assign mem_clken = 1'b1;

    // Sequencer FSM plus read-response tracking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rid_q       <= REQ_M0;
            rlane_q     <= 1'b0;
        end else begin
            rvalid_q <= any_gnt && !sel_pl.we;
            rid_q    <= arb_gnt[1];
            rlane_q  <= sel_lane;
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + MEM_AW'(1);
                    if (&clr_cnt_q) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Response routing; RAM data arrives unregistered so rdata follows it directly.
    assign rd_half   = rlane_q ? mem_readdata[WORD_W-1:HALF_W] : mem_readdata[HALF_W-1:0];
    assign m0_rvalid = reset_n && rvalid_q && (rid_q == REQ_M0);
    assign m1_rvalid = reset_n && rvalid_q && (rid_q == REQ_M1);
    assign m0_rdata  = m0_rvalid ? rd_half : '0;
    assign m1_rdata  = m1_rvalid ? rd_half : '0;
    assign init_done = reset_n && init_done_q;

endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
// Bench for onchip_mem_port_arbiter: RAM emulation, a transaction-level
// reference model checked every cycle, directed literal checks and random traffic.
module tb_onchip_mem_port_arbiter;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [8:0]  mem_address;
    logic        mem_chipselect, mem_write, mem_clken, init_done;
    logic [7:0]  mem_byteenable;
    logic [63:0] mem_writedata;
    logic [63:0] mem_readdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    onchip_mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .init_done(init_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // RAM emulation: synchronous write, registered address, old data on read.
    logic [63:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = {$urandom, $urandom} | 64'h1;
    end
    always @(posedge clk) begin
        if (mem_chipselect) begin
            mem_readdata <= ram[mem_address];
            if (mem_write) begin
                for (int k = 0; k < 8; k++) begin
                    if (mem_byteenable[k]) ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
                end
            end
        end
    end

    // Reference model: 32-bit word memory, clear counter, last-grant id, pending read.
    logic [31:0] ref_mem [1024];
    bit          m_run;
    int          m_cnt;
    int          m_last;
    bit          pend_v;
    int          pend_id;
    logic [31:0] pend_d;

    initial begin : compare
        int          win;
        logic [9:0]  a;
        bit          w;
        logic [31:0] d;
        logic [3:0]  b;
        bit          e_cs, e_we, e_init, e_g0, e_g1, e_v0, e_v1;
        logic [63:0] e_addr, e_be, e_wd;
        logic [31:0] e_d0, e_d1;
        m_run = 0; m_cnt = 0; m_last = 1; pend_v = 0; pend_id = 0; pend_d = '0;
        forever begin
            @(negedge clk);
            e_cs = 0; e_we = 0; e_init = 0; e_g0 = 0; e_g1 = 0;
            e_addr = '0; e_be = '0; e_wd = '0;
            e_v0 = reset_n && pend_v && (pend_id == 0);
            e_v1 = reset_n && pend_v && (pend_id == 1);
            e_d0 = e_v0 ? pend_d : 32'h0;
            e_d1 = e_v1 ? pend_d : 32'h0;
            if (!reset_n) begin
                m_run = 0; m_cnt = 0; m_last = 1; pend_v = 0;
            end else if (!m_run) begin
                e_cs = 1; e_we = 1; e_be = 64'hFF; e_addr = 64'(m_cnt);
                ref_mem[2*m_cnt]   = 32'h0;
                ref_mem[2*m_cnt+1] = 32'h0;
                m_cnt++;
                if (m_cnt == DEPTH) m_run = 1;
                pend_v = 0;
            end else begin
                e_init = 1;
                win = -1;
                if (m0_req && m1_req) win = (m_last == 0) ? 1 : 0;
                else if (m0_req)      win = 0;
                else if (m1_req)      win = 1;
                pend_v = 0;
                if (win >= 0) begin
                    a = (win == 1) ? m1_addr  : m0_addr;
                    w = (win == 1) ? m1_we    : m0_we;
                    d = (win == 1) ? m1_wdata : m0_wdata;
                    b = (win == 1) ? m1_be    : m0_be;
                    e_g0 = (win == 0); e_g1 = (win == 1);
                    e_cs = 1; e_we = w;
                    e_addr = 64'(a >> 1);
                    e_be = a[0] ? (64'(b) << 4) : 64'(b);
                    e_wd = {d, d};
                    m_last = win;
                    if (w) begin
                        for (int k = 0; k < 4; k++) if (b[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
                    end else begin
                        pend_v = 1; pend_id = win; pend_d = ref_mem[a];
                    end
                end
            end
            check("m0_gnt", m0_gnt, e_g0);
            check("m1_gnt", m1_gnt, e_g1);
            check("chipselect", mem_chipselect, e_cs);
            check("init_done", init_done, e_init);
            check("m0_rvalid", m0_rvalid, e_v0);
            check("m1_rvalid", m1_rvalid, e_v1);
            check("m0_rdata", m0_rdata, e_d0);
            check("m1_rdata", m1_rdata, e_d1);
            check("clken", mem_clken, 1);
            if (e_cs) begin
                check("address", mem_address, e_addr);
                check("write", mem_write, e_we);
                check("byteenable", mem_byteenable, e_be);
                if (e_we) check("writedata", mem_writedata, e_wd);
            end else if (!reset_n) begin
                check("rst_write", mem_write, 0);
                check("rst_be", mem_byteenable, 0);
            end
        end
    end

    task automatic set_m(input int m, input bit req, input bit we, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (m == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be; end
        else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles after reset release until init_done (or stop_at); bounded.
    task automatic wait_init(input int stop_at, output int cyc, output logic [8:0] a1, output bit rv1);
        cyc = 0; a1 = '1; rv1 = 1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin a1 = mem_address; rv1 = m0_rvalid | m1_rvalid; end
            if (init_done || cyc == stop_at) return;
        end
        cyc = 9999;
    endtask

    task automatic new_req(input int m);
        logic [9:0] a;
        a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
        set_m(m, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    endtask

    task automatic run_random(input int ncyc);
        bit g0, g1;
        g0 = 1; g1 = 1;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (!m0_req || g0) new_req(0);
            if (!m1_req || g1) new_req(1);
            @(negedge clk);
            g0 = m0_gnt; g1 = m1_gnt;
        end
        tick();
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
    endtask

    initial begin : driver
        int         cyc;
        logic [8:0] a1;
        bit         rv1;
        int         nz;
        reset_n = 0;
        set_m(0, 1, 0, 0, 0, 4'hF);
        set_m(1, 1, 0, 1, 0, 4'hF);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        // Zero-fill: requests held during CLEAR, duration and final RAM contents.
        wait_init(-1, cyc, a1, rv1);
        check("clear_init_cycle", cyc, 513);
        check("clear_first_addr", a1, 0);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] != 64'h0) nz++;
        check("clear_nonzero_words", nz, 0);
        tick();
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Single write then read on lane 1.
        set_m(0, 1, 1, 10'd3, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        check("wr_gnt", m0_gnt, 1);
        check("wr_addr", mem_address, 1);
        check("wr_be", mem_byteenable, 8'hF0);
        tick();
        set_m(0, 1, 0, 10'd3, 0, 4'hF);
        @(negedge clk);
        check("rd_gnt", m0_gnt, 1);
        tick();
        set_m(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rd_rvalid", m0_rvalid, 1);
        check("rd_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd_other_rvalid", m1_rvalid, 0);

        // Byte lanes: single-byte write to addr 0, neighbour word untouched.
        tick();
        set_m(1, 1, 1, 10'd0, 32'h776655AA, 4'h1);
        @(negedge clk);
        check("bl_wr_be", mem_byteenable, 8'h01);
        tick();
        set_m(1, 1, 0, 10'd0, 0, 4'hF);
        tick();
        set_m(1, 1, 0, 10'd1, 0, 4'hF);
        @(negedge clk);
        check("bl_rd0", m1_rdata, 32'h000000AA);
        tick();
        set_m(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("bl_rd1_valid", m1_rvalid, 1);
        check("bl_rd1", m1_rdata, 32'h0);

        // Contention: last grant was m1, so grants alternate starting with m0.
        tick();
        set_m(0, 1, 0, 10'd3, 0, 4'hF);
        set_m(1, 1, 0, 10'd0, 0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ct_gnt0", m0_gnt, (i % 2) == 0);
            check("ct_gnt1", m1_gnt, (i % 2) == 1);
            if (i > 0) begin
                check("ct_rv0", m0_rvalid, (i % 2) == 1);
                check("ct_rdata", m0_rvalid ? m0_rdata : m1_rdata,
                      ((i % 2) == 1) ? 32'hDEADBEEF : 32'h000000AA);
            end
            tick();
        end
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("ct_last_rv1", m1_rvalid, 1);
        check("ct_last_rd1", m1_rdata, 32'h000000AA);

        run_random(1500);

        // Reset on a read-grant cycle: no response afterwards, clear restarts.
        tick();
        set_m(0, 1, 0, 10'd3, 0, 4'hF);
        reset_n = 0;
        @(negedge clk);
        check("rst_run_gnt", m0_gnt, 0);
        tick();
        reset_n = 1;
        set_m(0, 0, 0, 0, 0, 0);
        wait_init(200, cyc, a1, rv1);
        check("rst_run_no_rvalid", rv1, 0);
        check("rst_run_restart_addr", a1, 0);
        check("clr200_prev_addr", mem_address, 199);

        // Reset with the clear counter at 200.
        tick();
        reset_n = 0;
        @(negedge clk);
        check("clr200_cs_in_reset", mem_chipselect, 0);
        tick();
        reset_n = 1;
        wait_init(-1, cyc, a1, rv1);
        check("clr200_restart_addr", a1, 0);
        check("clr200_init_cycle", cyc, 513);

        run_random(800);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
